rho: RTL and testbench
======================

RHO -- requirements
Module: rho

Interface
REQ-001 The block SHALL have no parameters; lane width is fixed at 64 and the state at 1600 bits.
REQ-002 clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  qualifies `in` in the current cycle.
REQ-005 in  input  1600  Keccak state before the rho step.
REQ-006 out_valid  output  1  high when `out` holds a rho result.
REQ-007 out  output  1600  Keccak state after the rho step, registered.

Function
REQ-008 Lane (x,y), x,y in 0..4, SHALL occupy bits [64*(5y+x)+63 : 64*(5y+x)], with bit z at index 64*(5y+x)+z.
REQ-009 Each output lane SHALL be the input lane rotated left by r(x,y): out_lane[(z+r) mod 64] = in_lane[z].
REQ-010 Offsets by lane index 5y+x, 0..24, SHALL be: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
REQ-011 Lane 0 (offset 0) SHALL pass through unchanged.
REQ-012 The rotation SHALL be pure wiring with no arithmetic, and modulo-64 wrap-around SHALL be exact for every lane.
REQ-013 Latency SHALL be one cycle: on a rising edge with in_valid=1, out <= rho(in) and out_valid <= 1.
REQ-014 On a rising edge with in_valid=0, out SHALL hold its previous value and out_valid SHALL go 0.
REQ-015 Back-to-back valid inputs SHALL be accepted every cycle, so throughput is one state per cycle.
REQ-016 The block SHALL have no backpressure and no ready signal.
REQ-017 X on `in` while in_valid=0 SHALL NOT affect `out`.

Reset
REQ-018 While rst=1, out SHALL be 0 and out_valid SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-019 When reset is asserted mid-stream, the in-flight result SHALL be discarded.
REQ-020 The first capture after rst deasserts SHALL occur on the first rising edge at which in_valid=1.

Structure
REQ-021 The offset table, lane width (64) and state width (1600) SHALL live in the shared sha3 package for reuse by theta, pi, chi and iota.
REQ-022 One sub-module, rho_comb, SHALL implement the pure combinational rotation of REQ-009 to REQ-012.
REQ-023 The rho top level SHALL add only the valid/output register stage around rho_comb.
REQ-024 rho_comb SHALL be testable standalone with zero latency.

Verification
REQ-025 Drive in = bit 64 set (lane 1, z=0) with in_valid=1 -> after one edge, out = only bit 65 set and out_valid=1.
REQ-026 Drive in = bit 130 set (lane 2, z=2, offset 62) -> out = only bit 128 set (wrap-around).
REQ-027 Drive in = all ones -> out = all ones; drive in = lane 0 = 64'h0123456789ABCDEF with all other lanes 0 -> out lane 0 is unchanged.
REQ-028 Drive 20 random states with in_valid=1 every cycle -> each out matches the software Keccak rho model one cycle later, with no bubbles.
REQ-029 Assert rst between clock edges while out_valid=1 -> out=0 and out_valid=0 immediately.
REQ-030 Deassert rst with in_valid=0 -> out_valid stays 0 and out stays 0.
REQ-031 Hold in_valid=0 with random `in` -> out holds its last value.

Source files
------------

// File: rtl/sha3_pkg.sv
// ============================================================================
//  Module      : sha3_pkg
//  Description : Shared Keccak-f[1600] constants and types used by the
//                theta, rho, pi, chi and iota step blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha3_pkg;

    // Lane width, number of lanes and total state width of Keccak-f[1600]
    localparam int c_lane_w    = 64;
    localparam int c_num_lanes = 25;
    localparam int c_state_w   = c_lane_w * c_num_lanes;

    typedef logic [c_lane_w-1:0]  lane_t;
    typedef logic [c_state_w-1:0] state_t;

    // Rho rotation offsets indexed by lane number 5*y + x
    localparam int c_rho_offsets [c_num_lanes] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    // Lane number for coordinates (x, y)
    function automatic int lane_index(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rho_comb.sv
// ============================================================================
//  Module      : rho_comb
//  Description : Keccak rho step as pure wiring. Every lane is rotated left
//                by its fixed offset; no logic cells, zero latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rho_comb
    import sha3_pkg::*;
(
    input  logic [c_state_w-1:0] state_i,
    output logic [c_state_w-1:0] state_o
);

    // Per-bit routing: input bit z of a lane lands on bit (z + r) mod 64.
    // Doing it bit by bit keeps the zero-offset lane free of empty slices
    // and makes the wrap-around exact by construction.
    for (genvar g_l = 0; g_l < c_num_lanes; g_l++) begin : g_lane
        localparam int c_r = c_rho_offsets[g_l];
        for (genvar g_z = 0; g_z < c_lane_w; g_z++) begin : g_bit
            assign state_o[g_l*c_lane_w + ((g_z + c_r) % c_lane_w)] =
                   state_i[g_l*c_lane_w + g_z];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rho.sv
// ============================================================================
//  Module      : rho
//  Description : Registered Keccak rho step. Wraps rho_comb with a single
//                valid/output register stage; one state per cycle, no
//                backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rho
    import sha3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [c_state_w-1:0] in,
    output logic                 out_valid,
    output logic [c_state_w-1:0] out
);

    logic [c_state_w-1:0] w_rho;
    logic [c_state_w-1:0] out_d;
    logic [c_state_w-1:0] out_q;
    logic                 out_valid_d;
    logic                 out_valid_q;

    rho_comb u_rho_comb (
        .state_i (in),
        .state_o (w_rho)
    );

    // Next state: capture on valid, otherwise hold the data and drop valid.
    // The mux selects out_q when in_valid=0, so X on `in` never propagates.
    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = w_rho;
        end
    end

    // Output register stage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rho.sv
// ============================================================================
//  Module      : tb_rho
//  Description : Self-checking bench for rho against a lane-rotation model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rho;

    localparam int c_sw = 1600;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [c_sw-1:0] in_s = '0;
    logic            out_valid;
    logic [c_sw-1:0] out_s;

    int n_vec  = 0;
    int n_fail = 0;

    rho dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_s),
        .out_valid (out_valid),
        .out       (out_s)
    );

    always #5 clk = ~clk;

    // Keccak rho written as lane rotations with the standard offset table
    function automatic logic [c_sw-1:0] ref_rho(input logic [c_sw-1:0] s);
        int rot [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                         41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
        logic [c_sw-1:0] r;
        logic [63:0]     ln;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            ln = s[64*i +: 64];
            if (rot[i] != 0) ln = (ln << rot[i]) | (ln >> (64 - rot[i]));
            r[64*i +: 64] = ln;
        end
        return r;
    endfunction

    function automatic logic [c_sw-1:0] rand_state();
        logic [c_sw-1:0] r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [c_sw-1:0] obs,
                               input logic [c_sw-1:0] exp);
        int ln;
        n_vec++;
        ln = 0;
        for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) ln = i;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s lane %0d observed=%h expected=%h", tag, ln,
                   obs[64*ln +: 64], exp[64*ln +: 64]);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    // Directed and random stimulus sequence
    initial begin
        logic [c_sw-1:0] exp;
        logic [c_sw-1:0] last;
        logic [c_sw-1:0] stim;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_state("reset_out", out_s, '0);
        check_bit("reset_valid", out_valid, 1'b0);

        // Release reset with in_valid low: nothing captured
        rst = 1'b0;
        in_s = rand_state();
        step();
        check_bit("idle_valid", out_valid, 1'b0);
        check_state("idle_out", out_s, '0);

        // Single bit in lane 1 moves by one
        in_s = '0; in_s[64] = 1'b1; in_valid = 1'b1;
        step();
        exp = '0; exp[65] = 1'b1;
        check_state("lane1_bit", out_s, exp);
        check_bit("lane1_valid", out_valid, 1'b1);

        // Lane 2 bit 2 with offset 62 wraps to bit 0
        in_s = '0; in_s[130] = 1'b1;
        step();
        exp = '0; exp[128] = 1'b1;
        check_state("lane2_wrap", out_s, exp);

        // All ones are invariant
        in_s = '1;
        step();
        check_state("all_ones", out_s, {c_sw{1'b1}});

        // Lane 0 passes through unchanged
        in_s = '0; in_s[63:0] = 64'h0123456789ABCDEF;
        step();
        exp = '0; exp[63:0] = 64'h0123456789ABCDEF;
        check_state("lane0_pass", out_s, exp);

        // 20 back-to-back random states, one per cycle
        for (int k = 0; k < 20; k++) begin
            stim = rand_state();
            in_s = stim;
            step();
            check_state($sformatf("stream%0d", k), out_s, ref_rho(stim));
            check_bit($sformatf("stream%0d_valid", k), out_valid, 1'b1);
        end
        last = ref_rho(stim);

        // Hold with random and unknown input while in_valid is low
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_s = rand_state();
            step();
            check_state($sformatf("hold%0d", k), out_s, last);
            check_bit($sformatf("hold%0d_valid", k), out_valid, 1'b0);
        end
        in_s = 'x;
        step();
        check_state("hold_x", out_s, last);

        // Mid-stream asynchronous reset
        stim = rand_state();
        in_s = stim; in_valid = 1'b1;
        step();
        check_state("pre_rst_out", out_s, ref_rho(stim));
        check_bit("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst_out", out_s, '0);
        check_bit("async_rst_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        step();
        check_state("post_rst_out", out_s, '0);
        check_bit("post_rst_valid", out_valid, 1'b0);
        step();
        check_bit("post_rst_valid2", out_valid, 1'b0);

        // First capture after reset
        stim = rand_state();
        in_s = stim; in_valid = 1'b1;
        step();
        check_state("first_cap", out_s, ref_rho(stim));
        check_bit("first_cap_valid", out_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
